// File: rtl/i2s_sample_buffer.sv
// I2S master front end for a 24-bit microphone: generates SCK and WS,
// deserialises left/right samples and stores the left channel in a ping-pong
// RAM that a downstream consumer drains one bank at a time over valid/ready.
module i2s_sample_buffer #(
  parameter int SCK_HALF = 2,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sd_i,
  output logic               sck_o,
  output logic               ws_o,
  output logic               frame_start_o,
  output logic signed [23:0] left_o,
  output logic signed [23:0] right_o,
  output logic               sample_ready_o,
  output logic               write_ready_o,
  output logic [WIDTH-1:0]   read_data_o,
  output logic               read_valid_o,
  input  logic               read_ready_i,
  output logic               buffer_ready_o,
  output logic               buffer_overflow_o,
  output logic [8:0]         write_count_o,
  output logic [8:0]         read_count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_HALF - 1);
  localparam logic [8:0]    LAST_IDX = 9'(DEPTH - 1);
  localparam logic [8:0]    FULL_CNT = 9'(DEPTH);

  // clock generator state
  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic [5:0]    slot_q, slot_d;
  logic          frame_start_q, frame_start_d;
  logic          div_end, sck_rise, sck_fall;

  // capture state
  logic [23:0]   left_sr_q, left_sr_d;
  logic [23:0]   right_sr_q, right_sr_d;
  logic          load_q, load_d;
  logic [23:0]   left_q, left_d;
  logic [23:0]   right_q, right_d;
  logic          sample_ready_q, sample_ready_d;

  // ping-pong buffer state
  logic          fill_bank_q, fill_bank_d;
  logic          drain_busy_q, drain_busy_d;
  logic          pending_q, pending_d;
  logic [8:0]    write_count_q, write_count_d;
  logic [8:0]    read_count_q, read_count_d;
  logic          buffer_ready_q, buffer_ready_d;
  logic          overflow_q, overflow_d;
  logic          xfer, release_bank;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] read_data_q;

  logic [WIDTH-1:0] mem [2*DEPTH];

  // SCK divider and 64-slot frame counter; WS is the counter MSB
  always_comb begin
    div_end       = (div_q == DIV_LAST);
    sck_rise      = div_end && !sck_q;
    sck_fall      = div_end && sck_q;
    div_d         = div_end ? '0 : div_q + 1'b1;
    sck_d         = div_end ? !sck_q : sck_q;
    slot_d        = sck_fall ? slot_q + 6'd1 : slot_q;
    frame_start_d = sck_fall && (slot_q == 6'd63);
  end

  // shift data bits in on SCK rising edges and publish after right slot 24
  always_comb begin
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    if (sck_rise && (slot_q[4:0] != 5'd0) && (slot_q[4:0] <= 5'd24)) begin
      if (slot_q[5]) right_sr_d = {right_sr_q[22:0], sd_i};
      else           left_sr_d  = {left_sr_q[22:0], sd_i};
    end
    load_d         = sck_rise && (slot_q == 6'd56);
    left_d         = load_q ? left_sr_q : left_q;
    right_d        = load_q ? right_sr_q : right_q;
    sample_ready_d = load_q;
  end

  // bank bookkeeping: fill/drain swap, pending full bank and overflow drops
  always_comb begin
    fill_bank_d    = fill_bank_q;
    drain_busy_d   = drain_busy_q;
    pending_d      = pending_q;
    write_count_d  = write_count_q;
    read_count_d   = read_count_q;
    buffer_ready_d = 1'b0;
    overflow_d     = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = {fill_bank_q, write_count_q[AW-1:0]};
    wr_data        = WIDTH'(left_q);
    xfer           = drain_busy_q && read_ready_i;
    release_bank   = xfer && (read_count_q == LAST_IDX);

    if (xfer) begin
      if (release_bank) begin
        read_count_d = '0;
        drain_busy_d = 1'b0;
      end else begin
        read_count_d = read_count_q + 9'd1;
      end
    end

    if (pending_q) begin
      if (!drain_busy_q) begin
        fill_bank_d    = !fill_bank_q;
        drain_busy_d   = 1'b1;
        read_count_d   = '0;
        pending_d      = 1'b0;
        buffer_ready_d = 1'b1;
        write_count_d  = '0;
        if (sample_ready_q) begin
          wr_en         = 1'b1;
          wr_addr       = {!fill_bank_q, {AW{1'b0}}};
          write_count_d = 9'd1;
        end
      end else if (sample_ready_q) begin
        overflow_d = 1'b1;
      end
    end else if (sample_ready_q) begin
      wr_en = 1'b1;
      if (write_count_q == LAST_IDX) begin
        if (!drain_busy_q || release_bank) begin
          fill_bank_d    = !fill_bank_q;
          drain_busy_d   = 1'b1;
          read_count_d   = '0;
          buffer_ready_d = 1'b1;
          write_count_d  = '0;
        end else begin
          pending_d     = 1'b1;
          write_count_d = FULL_CNT;
        end
      end else begin
        write_count_d = write_count_q + 9'd1;
      end
    end

    rd_addr = {!fill_bank_d, read_count_d[AW-1:0]};
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q          <= '0;
      sck_q          <= 1'b0;
      slot_q         <= '0;
      frame_start_q  <= 1'b0;
      left_sr_q      <= '0;
      right_sr_q     <= '0;
      load_q         <= 1'b0;
      left_q         <= '0;
      right_q        <= '0;
      sample_ready_q <= 1'b0;
      fill_bank_q    <= 1'b0;
      drain_busy_q   <= 1'b0;
      pending_q      <= 1'b0;
      write_count_q  <= '0;
      read_count_q   <= '0;
      buffer_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      div_q          <= div_d;
      sck_q          <= sck_d;
      slot_q         <= slot_d;
      frame_start_q  <= frame_start_d;
      left_sr_q      <= left_sr_d;
      right_sr_q     <= right_sr_d;
      load_q         <= load_d;
      left_q         <= left_d;
      right_q        <= right_d;
      sample_ready_q <= sample_ready_d;
      fill_bank_q    <= fill_bank_d;
      drain_busy_q   <= drain_busy_d;
      pending_q      <= pending_d;
      write_count_q  <= write_count_d;
      read_count_q   <= read_count_d;
      buffer_ready_q <= buffer_ready_d;
      overflow_q     <= overflow_d;
    end
  end

  // sample RAM write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // show-ahead read port addressed by the next read pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) read_data_q <= '0;
    else       read_data_q <= mem[rd_addr];
  end

  assign sck_o             = sck_q;
  assign ws_o              = slot_q[5];
  assign frame_start_o     = frame_start_q;
  assign left_o            = left_q;
  assign right_o           = right_q;
  assign sample_ready_o    = sample_ready_q;
  assign write_ready_o     = !pending_q;
  assign read_data_o       = read_data_q;
  assign read_valid_o      = drain_busy_q;
  assign buffer_ready_o    = buffer_ready_q;
  assign buffer_overflow_o = overflow_q;
  assign write_count_o     = write_count_q;
  assign read_count_o      = read_count_q;

endmodule

// File: tb/tb_i2s_sample_buffer.sv
// Scoreboard bench for i2s_sample_buffer: a microphone model pushes expected
// samples and RAM words as each frame is transmitted; a monitor pops and
// compares them whenever the DUT presents a sample or a read transfer.
module tb_i2s_sample_buffer;

   localparam int SCK_HALF = 2;
   localparam int WIDTH    = 32;
   localparam int DEPTH    = 32;
   localparam int FRAME    = 128 * SCK_HALF;
   localparam logic [23:0] RIGHT = 24'hABCDEF;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic sd_i = 1'b0;
   logic read_ready_i = 1'b0;
   logic sck_o, ws_o, frame_start_o, sample_ready_o, write_ready_o;
   logic signed [23:0] left_o, right_o;
   logic [WIDTH-1:0] read_data_o;
   logic read_valid_o, buffer_ready_o, buffer_overflow_o;
   logic [8:0] write_count_o, read_count_o;

   i2s_sample_buffer #(.SCK_HALF(SCK_HALF), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .sd_i(sd_i), .sck_o(sck_o), .ws_o(ws_o),
      .frame_start_o(frame_start_o), .left_o(left_o), .right_o(right_o),
      .sample_ready_o(sample_ready_o), .write_ready_o(write_ready_o),
      .read_data_o(read_data_o), .read_valid_o(read_valid_o),
      .read_ready_i(read_ready_i), .buffer_ready_o(buffer_ready_o),
      .buffer_overflow_o(buffer_overflow_o), .write_count_o(write_count_o),
      .read_count_o(read_count_o));

   always #5 clk_i = ~clk_i;

   int nChecks = 0;
   int nFails = 0;

   logic [23:0] expLeft[$];
   logic [23:0] expRight[$];
   logic [WIDTH-1:0] expReads[$];

   int micSlot = 0;
   int micFrame = 0;
   logic micPrevSck = 1'b0;
   logic rstSeen = 1'b1;
   bit pushPending = 1'b0;
   int dropLo = -1;
   int dropHi = -2;

   int cyc = 0;
   int sampleCount = 0;
   int brCount = 0;
   int ovfCount = 0;
   int readsDone = 0;
   int fsCount = 0;
   int brAt[$];
   int lastSampleCyc = 0;
   int relCyc = 0;
   bit haveLast = 1'b0;
   bit checkWc = 1'b0;
   bit wcDue = 1'b0;

   // left sample carried by frame n; distinct per frame so ordering is visible
   function automatic logic [23:0] leftOf(input int n);
      return 24'h123456 + 24'(n * 32'h010203);
   endfunction

   // serial bit the microphone drives for a given slot of a given frame
   function automatic logic micBit(input int slot, input int frame);
      int pos;
      logic [23:0] w;
      pos = slot % 32;
      if (pos < 1 || pos > 24) return 1'b1;
      w = (slot < 32) ? leftOf(frame) : RIGHT;
      return w[24-pos];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic failNote(input string name, input logic [31:0] actual);
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected no event (scoreboard empty)", name, actual);
   endtask

   task automatic pushFrame(input int n);
      expLeft.push_back(leftOf(n));
      expRight.push_back(RIGHT);
      if (!(n >= dropLo && n <= dropHi)) expReads.push_back(WIDTH'(leftOf(n)));
   endtask

   // drive inputs just after the active edge
   task automatic applyStimulus(input logic rst, input logic rdy);
      @(posedge clk_i);
      #1;
      rst_i = rst;
      read_ready_i = rdy;
   endtask

   task automatic doReset(input logic rdy);
      applyStimulus(1'b1, rdy);
      repeat (10) @(posedge clk_i);
      applyStimulus(1'b0, rdy);
   endtask

   task automatic waitSamples(input int n, input string what);
      int k;
      k = 0;
      while (sampleCount < n && k < (n + 2) * FRAME) begin
         @(posedge clk_i);
         k++;
      end
      if (sampleCount < n) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL %s timeout: got %0d samples, expected %0d", what, sampleCount, n);
      end
   endtask

   task automatic measureClocks();
      int t0, t1, k;
      logic prev;
      t0 = -1; t1 = -1; k = 0; prev = sck_o;
      while (t1 < 0 && k < 100) begin
         @(negedge clk_i);
         if (!prev && sck_o) begin
            if (t0 < 0) t0 = k;
            else t1 = k;
         end
         prev = sck_o;
         k++;
      end
      checkOutput("sck_period", 32'(t1 - t0), 32'(2 * SCK_HALF));
      t0 = -1; t1 = -1; k = 0; prev = ws_o;
      while (t1 < 0 && k < 3 * FRAME) begin
         @(negedge clk_i);
         if (!prev && ws_o) t0 = k;
         else if (prev && !ws_o && t0 >= 0) t1 = k;
         prev = ws_o;
         k++;
      end
      checkOutput("ws_high_cycles", 32'(t1 - t0), 32'(FRAME / 2));
   endtask

   // microphone model: follows SCK falls, drives SD and issues expectations per frame
   always @(posedge clk_i) begin
      rstSeen = rst_i;
      #2;
      if (rstSeen) begin
         micSlot = 0;
         micFrame = 0;
         micPrevSck = 1'b0;
         expLeft.delete();
         expRight.delete();
         expReads.delete();
         pushPending = 1'b1;
      end else begin
         if (pushPending) begin
            pushFrame(micFrame);
            pushPending = 1'b0;
         end
         if (micPrevSck && !sck_o) begin
            micSlot = (micSlot + 1) % 64;
            if (micSlot == 0) begin
               micFrame++;
               pushFrame(micFrame);
            end
         end
         micPrevSck = sck_o;
      end
      sd_i = micBit(micSlot, micFrame);
   end

   // monitor: pops expectations whenever the DUT presents an output event
   always @(negedge clk_i) begin
      cyc++;
      if (rst_i) begin
         sampleCount = 0;
         brCount = 0;
         ovfCount = 0;
         readsDone = 0;
         fsCount = 0;
         brAt.delete();
         haveLast = 1'b0;
         wcDue = 1'b0;
         relCyc = cyc;
      end else begin
         if (wcDue) begin
            checkOutput("write_count_step", 32'(write_count_o), 32'(sampleCount % DEPTH));
            wcDue = 1'b0;
         end
         if (sample_ready_o) begin
            sampleCount++;
            if (expLeft.size() == 0) begin
               failNote("sample_unexpected", {8'h00, left_o});
            end else begin
               checkOutput("left_o", {8'h00, left_o}, {8'h00, expLeft.pop_front()});
               checkOutput("right_o", {8'h00, right_o}, {8'h00, expRight.pop_front()});
            end
            if (haveLast) checkOutput("sample_spacing", 32'(cyc - lastSampleCyc), 32'(FRAME));
            else checkOutput("first_sample_latency_ok", 32'(cyc - relCyc <= FRAME), 32'd1);
            haveLast = 1'b1;
            lastSampleCyc = cyc;
            if (checkWc) wcDue = 1'b1;
         end
         if (buffer_overflow_o) ovfCount++;
         if (buffer_ready_o) begin
            brCount++;
            brAt.push_back(sampleCount);
         end
         if (frame_start_o) fsCount++;
         if (read_valid_o && read_ready_i) begin
            readsDone++;
            if (expReads.size() == 0) failNote("read_unexpected", read_data_o);
            else checkOutput("read_data", read_data_o, expReads.pop_front());
         end
      end
   end

   // watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got %0d assertions, expected completion", nChecks);
      $fatal(1, "[TB] watchdog");
   end

   // directed test sequence
   initial begin
      logic anyPulse;

      $display("[TB] reset check");
      rst_i = 1'b1;
      read_ready_i = 1'b0;
      repeat (10) @(posedge clk_i);
      applyStimulus(1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput("rst_write_ready", 32'(write_ready_o), 32'd1);
      checkOutput("rst_read_valid", 32'(read_valid_o), 32'd0);
      checkOutput("rst_write_count", 32'(write_count_o), 32'd0);
      checkOutput("rst_read_count", 32'(read_count_o), 32'd0);
      checkOutput("rst_sck_ws", {30'd0, sck_o, ws_o}, 32'd0);
      checkOutput("rst_left_right", {8'h00, left_o} | {8'h00, right_o}, 32'd0);
      checkOutput("rst_read_data", read_data_o, 32'd0);
      anyPulse = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         anyPulse = anyPulse | sample_ready_o | buffer_ready_o | buffer_overflow_o | frame_start_o;
      end
      checkOutput("rst_no_pulses", 32'(anyPulse), 32'd0);

      $display("[TB] capture, fill and ping-pong with continuous read");
      checkWc = 1'b1;
      doReset(1'b1);
      measureClocks();
      waitSamples(100, "pingpong");
      @(negedge clk_i);
      checkOutput("pp_buffer_ready_count", 32'(brCount), 32'd3);
      checkOutput("pp_br0_at_sample", 32'(brAt.size() > 0 ? brAt[0] : -1), 32'd32);
      checkOutput("pp_br1_at_sample", 32'(brAt.size() > 1 ? brAt[1] : -1), 32'd64);
      checkOutput("pp_br2_at_sample", 32'(brAt.size() > 2 ? brAt[2] : -1), 32'd96);
      checkOutput("pp_overflow_count", 32'(ovfCount), 32'd0);
      checkOutput("pp_reads_done", 32'(readsDone), 32'd96);
      checkOutput("pp_frame_starts", 32'(fsCount), 32'd99);
      checkWc = 1'b0;

      $display("[TB] overflow with stalled reader");
      dropLo = 64;
      dropHi = 69;
      doReset(1'b0);
      waitSamples(64, "overflow_fill");
      repeat (2) @(negedge clk_i);
      checkOutput("ovf_write_ready_low", 32'(write_ready_o), 32'd0);
      checkOutput("ovf_first_handover", 32'(brCount), 32'd1);
      checkOutput("ovf_read_valid", 32'(read_valid_o), 32'd1);
      checkOutput("ovf_none_yet", 32'(ovfCount), 32'd0);
      waitSamples(70, "overflow_drop");
      repeat (2) @(negedge clk_i);
      checkOutput("ovf_drop_count", 32'(ovfCount), 32'd6);
      checkOutput("ovf_still_blocked", 32'(write_ready_o), 32'd0);
      applyStimulus(1'b0, 1'b1);
      repeat (31) @(posedge clk_i);
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(negedge clk_i);
      checkOutput("ovf_swap_buffer_ready", 32'(brCount), 32'd2);
      checkOutput("ovf_bank_a_reads", 32'(readsDone), 32'd32);
      checkOutput("ovf_write_ready_back", 32'(write_ready_o), 32'd1);
      checkOutput("ovf_bank_b_valid", 32'(read_valid_o), 32'd1);
      checkOutput("ovf_read_count_zero", 32'(read_count_o), 32'd0);
      applyStimulus(1'b0, 1'b1);
      waitSamples(72, "overflow_recover");
      @(negedge clk_i);
      checkOutput("ovf_new_fill_count", 32'(write_count_o), 32'd2);
      checkOutput("ovf_bank_b_reads", 32'(readsDone), 32'd64);
      checkOutput("ovf_no_new_drops", 32'(ovfCount), 32'd6);

      $display("[TB] reset in the middle of a buffer");
      dropLo = -1;
      dropHi = -2;
      doReset(1'b1);
      waitSamples(10, "midreset_fill");
      @(negedge clk_i);
      checkOutput("mid_write_count_10", 32'(write_count_o), 32'd10);
      applyStimulus(1'b1, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("mid_rst_write_count", 32'(write_count_o), 32'd0);
      checkOutput("mid_rst_read_count", 32'(read_count_o), 32'd0);
      checkOutput("mid_rst_write_ready", 32'(write_ready_o), 32'd1);
      checkOutput("mid_rst_read_valid", 32'(read_valid_o), 32'd0);
      checkOutput("mid_rst_left", {8'h00, left_o}, 32'd0);
      checkOutput("mid_rst_sck", 32'(sck_o), 32'd0);
      repeat (3) @(posedge clk_i);
      applyStimulus(1'b0, 1'b1);
      begin
         int k;
         k = 0;
         while (brCount < 1 && k < 34 * FRAME) begin
            @(negedge clk_i);
            k++;
         end
      end
      checkOutput("mid_br_at_sample", 32'(brAt.size() > 0 ? brAt[0] : -1), 32'd32);
      repeat (40) @(negedge clk_i);
      checkOutput("mid_reads_done", 32'(readsDone), 32'd32);
      checkOutput("mid_overflow_count", 32'(ovfCount), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/i2s_sample_buffer.md
# i2s_sample_buffer

Audio front end that generates the I2S bit clock and word select for a 24-bit I2S microphone, deserialises the left and right samples, and stores the left channel in a ping-pong RAM. It sits between the microphone pins and a downstream consumer, such as the VU meter, that drains one full buffer at a time through a valid/ready port. Sample capture, buffering and overflow detection are all in a single clock domain.

## Interface
- SCK_HALF, default 2: clk_i cycles per SCK half-period. SCK = clk_i/(2·SCK_HALF); one frame = 128·SCK_HALF clk_i cycles.
- WIDTH, default 32: RAM word width, ≥24.
- DEPTH, default 256: words per bank. Power of two, 2..256.
- clk_i  in  1  system clock (27 MHz nominal).
- rst_i  in  1  reset. Synchronous and active-high.
- sd_i  in  1  I2S serial data from the microphone.
- sck_o  out  1  I2S bit clock.
- ws_o  out  1  word select: 0 = left slot, 1 = right slot.
- frame_start_o  out  1  one-cycle pulse when ws_o falls.
- left_o, right_o  out  24 each  last captured samples, signed.
- sample_ready_o  out  1  one-cycle pulse when left_o/right_o update.
- write_ready_o  out  1  a free bank can accept samples.
- read_data_o  out  WIDTH  word at the read pointer, `{zero pad, left sample}`.
- read_valid_o  out  1  read_data_o is valid.
- read_ready_i  in  1  consumer accepts read_data_o.
- buffer_ready_o  out  1  one-cycle pulse when a bank is handed to the reader.
- buffer_overflow_o  out  1  one-cycle pulse per dropped sample.
- write_count_o, read_count_o  out  9 each  words written to the fill bank / read from the drain bank.

## Operation
- Clock generator:
  - Divider toggles sck_o every SCK_HALF cycles; sck_o starts low.
  - A 6-bit slot counter advances on each SCK falling edge. ws_o = counter[5].
  - frame_start_o pulses when the counter wraps 63→0.
- Capture:
  - On the clk_i cycle of each SCK rising edge, sample sd_i into slot counter[4:0].
  - Slot 0 is the one-bit I2S delay. Slots 1..24 carry data MSB first. Slots 25..31 are ignored.
  - After right-channel slot 24, on the next cycle: load left_o and right_o from the shift registers and pulse sample_ready_o.
- Write side:
  - Each sample_ready_o writes `{(WIDTH-24)'b0, left}` to the fill bank at write_count_o, then write_count_o increments.
  - When write_count_o reaches DEPTH and the other bank is free, the banks swap:
    - write_count_o returns to 0;
    - the filled bank becomes the drain bank;
    - buffer_ready_o pulses and read_valid_o rises.
  - If the other bank is still draining, the full bank is held pending and write_ready_o goes low.
  - While pending, every sample_ready_o is dropped and buffer_overflow_o pulses. The swap happens on the cycle after the reader releases its bank.
- Read side:
  - read_valid_o is high while the drain bank has unread words. read_data_o is show-ahead: the word at read_count_o.
  - A transfer occurs when read_valid_o && read_ready_i; read_count_o then increments.
  - After the DEPTH-th transfer: read_count_o returns to 0, read_valid_o falls, and the bank becomes free.
- Simultaneous events:
  - Release and fill on the same cycle: the swap succeeds with no overflow.
  - Sample arrival on the cycle a pending swap completes: the sample is written to the new fill bank at index 0.

## Timing
- Reset values: sck_o=0, ws_o=0, slot counter 0, frame_start_o=0, left_o=right_o=0, sample_ready_o=0, write_ready_o=1, read_valid_o=0, read_data_o=0, buffer_ready_o=0, buffer_overflow_o=0, both counts 0, both banks free.
- Reset mid-operation aborts any frame or buffer. RAM contents need not be cleared.
- The first sample_ready_o occurs within 128·SCK_HALF cycles of reset release (≤256 at default). Subsequent pulses are exactly 128·SCK_HALF apart.
- buffer_ready_o and read_valid_o rise the cycle after the DEPTH-th write is registered.
- read_data_o updates the cycle after each transfer, so back-to-back transfers at one word per cycle are supported.

## Test plan
- Reset: hold rst_i 10 cycles, release -> write_ready_o=1, read_valid_o=0, all counts 0, no pulses for 5 cycles.
- Capture: SCK_HALF=2, drive left 0x123456 and right 0xABCDEF per I2S format -> sample_ready_o pulses every 256 cycles with left_o=0x123456 and right_o=0xABCDEF; sck_o period 4; ws_o high for 128 cycles.
- Fill: DEPTH=32, read_ready_i=1 -> buffer_ready_o after the 32nd sample; write_count_o steps 0..31 then 0; the consumer reads 32 words equal to `{8'h00, left}` in write order.
- Ping-pong: DEPTH=32, continuous read -> ≥3 buffer_ready_o pulses 32 samples apart with zero overflow pulses.
- Overflow: DEPTH=32, read_ready_i=0 -> the first bank is handed over, the second fills, write_ready_o=0, and samples 65 onward each pulse buffer_overflow_o. Raising read_ready_i for 32 cycles -> swap and buffer_ready_o.
- Mid-buffer reset: assert rst_i after 10 writes -> all reset values restored; the next buffer_ready_o follows 32 fresh samples.
